// File: rtl/mult_share_pkg.sv
// Shared constants, helpers and tag type for the shared-multiplier arbiter.
// Optional feature macro used by the top: MULT_SHARE_ARB_STATS_EN.
package mult_share_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MULT_LAT = 2;

    // Requester id width; a single requester still needs one id bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

    // Issue tag for the default configuration; the top re-declares it at its own ID_W.
    typedef struct packed {
        logic                valid;
        logic [DEF_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search with a pointer that advances past each grant.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;

    // Search from rr_ptr upward; walking backwards lets the closest valid win.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant_id  = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
        if (rst) grant_vld = 1'b0;
        if (grant_vld) grant[grant_id] = 1'b1;
    end

    // Pointer moves to the requester after the one just granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one external registered multiplier among NUM_REQ requesters.
// Issue tags track the core latency so each product returns with its id.
// Optional macro MULT_SHARE_ARB_STATS_EN adds per-requester accept counters.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int ID_W     = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     busy
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } pipe_tag_t;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;

    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    pipe_tag_t          tag_q [MULT_LAT+1];
    pipe_tag_t          tag_d [MULT_LAT+1];
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    assign req_ready = grant;

    // Operand mux into the core; holds when nothing is accepted.
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (grant_vld) begin
            mul_a_d = req_a[int'(grant_id)*WIDTH +: WIDTH];
            mul_b_d = req_b[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    // Tag pipe: stage 0 aligns with the operands, last stage with mul_p.
    always_comb begin
        tag_d[0].valid = grant_vld;
        tag_d[0].id    = grant_id;
        for (int s = 1; s <= MULT_LAT; s++) tag_d[s] = tag_q[s-1];
    end

    // Response capture when the last tag stage is valid.
    always_comb begin
        rsp_valid_d   = tag_q[MULT_LAT].valid;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        if (tag_q[MULT_LAT].valid) begin
            rsp_id_d      = tag_q[MULT_LAT].id;
            rsp_product_d = mul_p;
        end
    end

    // Busy while anything is in the tag pipe or a response is being presented.
    always_comb begin
        busy = rsp_valid_q;
        for (int s = 0; s <= MULT_LAT; s++) busy = busy | tag_q[s].valid;
    end

    // State registers; reset drops every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            for (int s = 0; s <= MULT_LAT; s++) tag_q[s] <= '0;
        end else begin
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            for (int s = 0; s <= MULT_LAT; s++) tag_q[s] <= tag_d[s];
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;

`ifdef MULT_SHARE_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];
    logic [15:0] stat_d [NUM_REQ];

    // Saturating accept counter for the granted requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) stat_d[i] = stat_q[i];
        if (grant_vld && (stat_q[grant_id] != 16'hFFFF)) begin
            stat_d[grant_id] = stat_q[grant_id] + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) stat_q[i] <= '0;
            else     stat_q[i] <= stat_d[i];
        end
    end

    // Pack counters onto the output port.
    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed table-driven bench for mult_share_arbiter with a 2-register core model.
// Define MULT_SHARE_ARB_STATS_EN to also exercise the accept counters.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [3:0]  req_ready;
    // Requester operands {r3,r2,r1,r0}: a = {-5,3,7,-8}, b = {3,-2,7,-8}
    logic [15:0] req_a = 16'hB378;
    logic [15:0] req_b = 16'h3E78;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic        busy;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic [63:0] stat_grants;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_share_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
`ifdef MULT_SHARE_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    // Core model: input register then output register.
    logic signed [7:0] sa, sb;
    logic [7:0]        p1, p2;
    assign sa = {{4{mul_a[3]}}, mul_a};
    assign sb = {{4{mul_b[3]}}, mul_b};
    always @(posedge clk) begin
        p1 <= sa * sb;
        p2 <= p1;
    end
    assign mul_p = p2;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] rdy;
        logic [3:0] ma;
        logic [3:0] mb;
        logic       rv;
        logic [1:0] rid;
        logic [7:0] rp;
        logic       busy;
    } vec_t;

    vec_t tbl [41];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] rdy, logic [3:0] ma,
                                logic [3:0] mb, logic rv, logic [1:0] rid, logic [7:0] rp,
                                logic bz);
        vec_t t;
        t.rst = r; t.v = v; t.rdy = rdy; t.ma = ma; t.mb = mb;
        t.rv = rv; t.rid = rid; t.rp = rp; t.busy = bz;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //                 rst  valid rdy   ma    mb    rv    id    prod   busy
        // reset held with all requesters valid
        tbl[0]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        tbl[1]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        tbl[2]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        // full contention: 0,1,2,3,0
        tbl[3]  = mk(1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        tbl[4]  = mk(1'b0, 4'hF, 4'h2, 4'h8, 4'h8, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[5]  = mk(1'b0, 4'hF, 4'h4, 4'h7, 4'h7, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[6]  = mk(1'b0, 4'hF, 4'h8, 4'h3, 4'hE, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[7]  = mk(1'b0, 4'hF, 4'h1, 4'hB, 4'h3, 1'b1, 2'd0, 8'h40, 1'b1);
        tbl[8]  = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2'd1, 8'h31, 1'b1);
        tbl[9]  = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2'd2, 8'hFA, 1'b1);
        tbl[10] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2'd3, 8'hF1, 1'b1);
        tbl[11] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2'd0, 8'h40, 1'b1);
        tbl[12] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h40, 1'b0);
        // single op from requester 2: 3 * -2
        tbl[13] = mk(1'b0, 4'h4, 4'h4, 4'h8, 4'h8, 1'b0, 2'd0, 8'h40, 1'b0);
        tbl[14] = mk(1'b0, 4'h0, 4'h0, 4'h3, 4'hE, 1'b0, 2'd0, 8'h40, 1'b1);
        tbl[15] = mk(1'b0, 4'h0, 4'h0, 4'h3, 4'hE, 1'b0, 2'd0, 8'h40, 1'b1);
        tbl[16] = mk(1'b0, 4'h0, 4'h0, 4'h3, 4'hE, 1'b0, 2'd0, 8'h40, 1'b1);
        tbl[17] = mk(1'b0, 4'h0, 4'h0, 4'h3, 4'hE, 1'b1, 2'd2, 8'hFA, 1'b1);
        tbl[18] = mk(1'b0, 4'h0, 4'h0, 4'h3, 4'hE, 1'b0, 2'd0, 8'hFA, 1'b0);
        // pointer at 3, requesters 1 and 3: 3,1,3; then requester 1 alone
        tbl[19] = mk(1'b0, 4'hA, 4'h8, 4'h3, 4'hE, 1'b0, 2'd0, 8'hFA, 1'b0);
        tbl[20] = mk(1'b0, 4'hA, 4'h2, 4'hB, 4'h3, 1'b0, 2'd0, 8'hFA, 1'b1);
        tbl[21] = mk(1'b0, 4'hA, 4'h8, 4'h7, 4'h7, 1'b0, 2'd0, 8'hFA, 1'b1);
        tbl[22] = mk(1'b0, 4'h2, 4'h2, 4'hB, 4'h3, 1'b0, 2'd0, 8'hFA, 1'b1);
        tbl[23] = mk(1'b0, 4'h2, 4'h2, 4'h7, 4'h7, 1'b1, 2'd3, 8'hF1, 1'b1);
        tbl[24] = mk(1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 1'b1, 2'd1, 8'h31, 1'b1);
        tbl[25] = mk(1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 1'b1, 2'd3, 8'hF1, 1'b1);
        tbl[26] = mk(1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 1'b1, 2'd1, 8'h31, 1'b1);
        tbl[27] = mk(1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 1'b1, 2'd1, 8'h31, 1'b1);
        tbl[28] = mk(1'b0, 4'h0, 4'h0, 4'h7, 4'h7, 1'b0, 2'd0, 8'h31, 1'b0);
        // three accepts (2,3,0), then reset drops them
        tbl[29] = mk(1'b0, 4'hF, 4'h4, 4'h7, 4'h7, 1'b0, 2'd0, 8'h31, 1'b0);
        tbl[30] = mk(1'b0, 4'hF, 4'h8, 4'h3, 4'hE, 1'b0, 2'd0, 8'h31, 1'b1);
        tbl[31] = mk(1'b0, 4'hF, 4'h1, 4'hB, 4'h3, 1'b0, 2'd0, 8'h31, 1'b1);
        tbl[32] = mk(1'b1, 4'hF, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h31, 1'b1);
        tbl[33] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        tbl[34] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        // pointer back at 0: all valid grants requester 0, -8 * -8
        tbl[35] = mk(1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        tbl[36] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[37] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[38] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h00, 1'b1);
        tbl[39] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2'd0, 8'h40, 1'b1);
        tbl[40] = mk(1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b0, 2'd0, 8'h40, 1'b0);

        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            req_valid = tbl[i].v;
            #1;
            chk($sformatf("v%0d req_ready", i),   32'(req_ready),   32'(tbl[i].rdy));
            chk($sformatf("v%0d mul_a", i),       32'(mul_a),       32'(tbl[i].ma));
            chk($sformatf("v%0d mul_b", i),       32'(mul_b),       32'(tbl[i].mb));
            chk($sformatf("v%0d rsp_valid", i),   32'(rsp_valid),   32'(tbl[i].rv));
            chk($sformatf("v%0d rsp_product", i), 32'(rsp_product), 32'(tbl[i].rp));
            chk($sformatf("v%0d busy", i),        32'(busy),        32'(tbl[i].busy));
            if (tbl[i].rv) chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].rid));
        end

`ifdef MULT_SHARE_ARB_STATS_EN
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        chk("stat cleared by rst", 32'(stat_grants[31:16]), 32'd0);
        rst       = 1'b0;
        req_valid = 4'h2;
        repeat (10) @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        chk("stat req1 after 10", 32'(stat_grants[31:16]), 32'd10);
        chk("stat req0 untouched", 32'(stat_grants[15:0]), 32'd0);
        req_valid = 4'h2;
        repeat (65530) @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        chk("stat req1 saturated", 32'(stat_grants[31:16]), 32'hFFFF);
        chk("stat req2 untouched", 32'(stat_grants[47:32]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter that time-shares one generated signed multiplier core among NUM_REQ requesters. It accepts at most one operand pair per cycle and drives it into the external multiplier. Issue tags follow the multiplier's fixed latency, so each product returns tagged with its requester id. It sits between client datapaths and a registered multiplier instance from the PPG/CPA generator flow.

Parameters:
WIDTH, 4, operand width; operands are signed two's complement; product is 2*WIDTH bits.
NUM_REQ, 4, number of requesters (>=2).
MULT_LAT, 2, cycles from mul_a/mul_b being driven to mul_p being valid. The default suits a core with an input register plus an output register.
ID_W, $clog2(NUM_REQ), requester id width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  packed multipliers, same packing
mul_a  output  WIDTH  registered multiplicand to the core
mul_b  output  WIDTH  registered multiplier to the core
mul_p  input  2*WIDTH  product from the core
rsp_valid  output  1  registered response valid, one-cycle pulse per operation
rsp_id  output  ID_W  requester index of the response
rsp_product  output  2*WIDTH  signed product
busy  output  1  any operation in flight or response pending

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values: rr_ptr=0; all tag-pipe valid bits=0; rsp_valid=0, rsp_id=0, rsp_product=0; mul_a=0, mul_b=0; busy=0. req_ready is forced to 0 while rst is high.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot grant; all zero if no valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: transfer occurs when req_valid[i] & req_ready[i] at a rising edge (the accept cycle, T).
  - On accept: mul_a, mul_b <= the granted requester's operands; rr_ptr <= (grant+1) mod NUM_REQ.
  - With no accept: rr_ptr, mul_a and mul_b hold.
- Fairness: a requester holding valid waits at most NUM_REQ-1 grants.
- Requester obligation: a requester holding valid must keep its operands stable until accepted.
- Tag pipe: MULT_LAT+1 stage shift register of {valid, id}, loaded at the accept edge and shifted every cycle.
- Capture: when the final stage is valid at cycle T+1+MULT_LAT, the block registers:
  - rsp_product <= mul_p
  - rsp_id <= tag id
  - rsp_valid <= 1
- Latency: rsp_valid is high in cycle T+2+MULT_LAT (T+4 at default).
- Throughput: one operation per cycle, no bubbles.
- Ordering: responses are in accept order.
- No response backpressure: consumers must sink rsp every cycle. rsp_product holds its last value when rsp_valid=0.
- Arithmetic: the block does no arithmetic. mul_p is passed through unmodified; sign correctness is the core's responsibility.
- busy = OR of tag-pipe valid bits OR rsp_valid.
- Boundaries:
  - All requesters valid every cycle: strict rotation 0,1,2,3,0,...
  - Single requester valid: granted every cycle.
  - rr_ptr at NUM_REQ-1 wraps to 0.
  - rst mid-operation: all in-flight operations are dropped and no rsp_valid pulse appears for them. The first accept after reset may occur in the first cycle with rst low.

Optional Feature:
Macro MULT_SHARE_ARB_STATS_EN.
- Defined: adds output stat_grants (NUM_REQ*16). It holds per-requester 16-bit saturating accept counters (saturate at 16'hFFFF), cleared by rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mult_share_pkg holds:
  - default WIDTH/NUM_REQ/MULT_LAT constants
  - ID width function
  - tag struct typedef {logic valid; logic [ID_W-1:0] id}
- One sub-module, rr_arbiter (NUM_REQ), containing the priority search plus rr_ptr register with advance-on-accept. The top level holds the operand mux, tag pipe and response registers.

Test Plan:
- Reset: assert rst 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0 throughout; the first grant after release goes to requester 0.
- Single op: req 2 sends a=3, b=-2 (4'hE) at cycle T -> mul_a=3, mul_b=4'hE in T+1; rsp_valid in T+4 with rsp_id=2, rsp_product=8'hFA; busy low from T+5.
- Full contention: all 4 valid continuously with distinct operands (including -8*-8=8'h40) -> grants 0,1,2,3,0,... one per cycle; responses back-to-back in the same order with correct products.
- Wrap and skip: rr_ptr=3, only requesters 1 and 3 valid -> grant 3, then 1, then 3; rr_ptr never selects an invalid requester.
- Reset mid-flight: accept 3 ops, assert rst one cycle later -> no rsp_valid pulses for them; the next op after reset returns correctly at accept+4.
- With MULT_SHARE_ARB_STATS_EN: 10 accepts to requester 1 -> stat_grants[31:16]=10; preload near saturation via 65540 accepts -> counter holds at 16'hFFFF.
